// File: rtl/strand_control_registers_if.sv
// -----------------------------------------------------------------------------
// strand_control_registers_if
// Control-register access bus between the memory-access stage (master) and
// the strand control register block (slave).
//   ex_strand          strand performing the access
//   ma_cr_index        register index
//   ma_cr_read_en      read strobe
//   ma_cr_write_en     write strobe
//   ma_cr_write_value  write data
//   cr_read_value      read data, valid one cycle after ma_cr_read_en
// -----------------------------------------------------------------------------
interface strand_control_registers_if #(
   parameter int NUM_STRANDS = 4
);
   localparam int SIW = (NUM_STRANDS > 1) ? $clog2(NUM_STRANDS) : 1;

   logic [SIW-1:0] ex_strand;
   logic [4:0]     ma_cr_index;
   logic           ma_cr_read_en;
   logic           ma_cr_write_en;
   logic [31:0]    ma_cr_write_value;
   logic [31:0]    cr_read_value;

   modport master (
      output ex_strand, ma_cr_index, ma_cr_read_en, ma_cr_write_en, ma_cr_write_value,
      input  cr_read_value
   );

   modport slave (
      input  ex_strand, ma_cr_index, ma_cr_read_en, ma_cr_write_en, ma_cr_write_value,
      output cr_read_value
   );
endinterface

// File: rtl/strand_control_registers.sv
// -----------------------------------------------------------------------------
// strand_control_registers
// Per-core control register block: strand ID, strand enable mask, exception
// handler, per-strand fault PC / cause / pending / double-fault, per-strand
// scratch registers and a free-running 64-bit cycle counter whose high half
// is snapshotted when the low half is read.
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   bus (slave)                   register access bus, registered read data
//   cr_strand_enable              strand run mask to the scheduler
//   cr_exception_handler_address  fault vector
//   cr_fault_pending              per-strand unacknowledged fault
//   wb_latch_fault/pc/cause/strand  fault report from writeback
// CYCLE_RESET is the counter value loaded at reset (0 for normal operation).
// -----------------------------------------------------------------------------
module strand_control_registers #(
   parameter int          NUM_STRANDS   = 4,
   parameter int          CORE_ID       = 0,
   parameter logic [31:0] RESET_HANDLER = 32'h0,
   parameter logic [63:0] CYCLE_RESET   = 64'h0,
   localparam int         SIW           = (NUM_STRANDS > 1) ? $clog2(NUM_STRANDS) : 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   strand_control_registers_if.slave bus,
   output logic [NUM_STRANDS-1:0]   cr_strand_enable,
   output logic [31:0]              cr_exception_handler_address,
   output logic [NUM_STRANDS-1:0]   cr_fault_pending,
   input  logic                     wb_latch_fault,
   input  logic [31:0]              wb_fault_pc,
   input  logic [3:0]               wb_fault_cause,
   input  logic [SIW-1:0]           wb_fault_strand
);

   typedef enum logic [4:0] {
      CR_STRAND_ID         = 5'd0,
      CR_EXCEPTION_HANDLER = 5'd1,
      CR_FAULT_ADDRESS     = 5'd2,
      CR_FAULT_CAUSE       = 5'd3,
      CR_STRAND_ENABLE     = 5'd4,
      CR_HALT_STRAND       = 5'd5,
      CR_RESUME_STRAND     = 5'd6,
      CR_HALT              = 5'd7,
      CR_CYCLE_LO          = 5'd8,
      CR_CYCLE_HI          = 5'd9,
      CR_SCRATCH0          = 5'd10,
      CR_SCRATCH1          = 5'd11,
      CR_FAULT_PENDING     = 5'd12
   } cr_index_e;

   // One extra bit so the strand count itself (e.g. 32) is representable.
   localparam logic [SIW:0] STRAND_LIMIT = NUM_STRANDS[SIW:0];

   // State
   logic [NUM_STRANDS-1:0] strand_enable;
   logic [31:0]            handler;
   logic [NUM_STRANDS-1:0] pending;
   logic [NUM_STRANDS-1:0] double_fault;
   logic [31:0]            saved_pc    [NUM_STRANDS];
   logic [3:0]             fault_cause [NUM_STRANDS];
   logic [31:0]            scratch0    [NUM_STRANDS];
   logic [31:0]            scratch1    [NUM_STRANDS];
   logic [63:0]            cycle_count;
   logic [31:0]            cycle_hi;
   logic [31:0]            read_value;

   // Decode
   cr_index_e              cr_index;
   logic                   ex_ok;
   logic                   fault_ok;
   logic                   resume_ok;
   logic [SIW-1:0]         resume_strand;
   logic                   read_legal;
   logic [NUM_STRANDS-1:0] enable_next;
   logic [NUM_STRANDS-1:0] pending_clear;
   logic [NUM_STRANDS-1:0] fault_hit;
   logic [31:0]            read_mux;

   assign cr_index      = cr_index_e'(bus.ma_cr_index);
   assign ex_ok         = {1'b0, bus.ex_strand} < STRAND_LIMIT;
   assign fault_ok      = {1'b0, wb_fault_strand} < STRAND_LIMIT;
   assign resume_strand = bus.ma_cr_write_value[SIW-1:0];
   assign resume_ok     = {1'b0, resume_strand} < STRAND_LIMIT;
   // A read colliding with a write is illegal; the write wins and the read
   // returns 0 without side effects (no hi snapshot).
   assign read_legal    = bus.ma_cr_read_en && !bus.ma_cr_write_en;

   // Strand enable next state
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      enable_next = strand_enable;
      if (bus.ma_cr_write_en) begin
         case (cr_index)
            CR_STRAND_ENABLE: enable_next = bus.ma_cr_write_value[NUM_STRANDS-1:0];
            CR_HALT_STRAND:   if (ex_ok) enable_next[bus.ex_strand] = 1'b0;
            CR_RESUME_STRAND: if (resume_ok) enable_next[resume_strand] = 1'b1;
            CR_HALT:          enable_next = '0;
            default:          ;
         endcase
      end
   end

   // Fault-pending clear mask and incoming fault, one bit per strand
   always_comb begin
      pending_clear = '0;
      fault_hit     = '0;
      if (bus.ma_cr_write_en && cr_index == CR_FAULT_PENDING)
         pending_clear = bus.ma_cr_write_value[NUM_STRANDS-1:0];
      if (wb_latch_fault && fault_ok)
         fault_hit[wb_fault_strand] = 1'b1;
   end

   // Read mux samples pre-update register values of the access cycle
   always_comb begin
      read_mux = '0;
      case (cr_index)
         CR_STRAND_ID:         read_mux = (32'(CORE_ID) << SIW) | 32'(bus.ex_strand);
         CR_EXCEPTION_HANDLER: read_mux = handler;
         CR_FAULT_ADDRESS:     if (ex_ok) read_mux = saved_pc[bus.ex_strand];
         CR_FAULT_CAUSE:       if (ex_ok) read_mux = {double_fault[bus.ex_strand], 27'b0,
                                                      fault_cause[bus.ex_strand]};
         CR_STRAND_ENABLE:     read_mux = 32'(strand_enable);
         CR_CYCLE_LO:          read_mux = cycle_count[31:0];
         CR_CYCLE_HI:          read_mux = cycle_hi;
         CR_SCRATCH0:          if (ex_ok) read_mux = scratch0[bus.ex_strand];
         CR_SCRATCH1:          if (ex_ok) read_mux = scratch1[bus.ex_strand];
         CR_FAULT_PENDING:     read_mux = 32'(pending);
         default:              read_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         strand_enable <= NUM_STRANDS'(1);
         handler       <= RESET_HANDLER;
         pending       <= '0;
         double_fault  <= '0;
         cycle_count   <= CYCLE_RESET;
         cycle_hi      <= '0;
         read_value    <= '0;
         // NOTE: the per-strand arrays are small flop arrays and are cleared
         // explicitly; they must not be mapped onto RAM, which has no reset.
         for (int s = 0; s < NUM_STRANDS; s++) begin
            saved_pc[s]    <= '0;
            fault_cause[s] <= '0;
            scratch0[s]    <= '0;
            scratch1[s]    <= '0;
         end
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         strand_enable <= enable_next;
         cycle_count   <= cycle_count + 64'd1;

         if (bus.ma_cr_write_en && cr_index == CR_EXCEPTION_HANDLER)
            handler <= bus.ma_cr_write_value;

         if (bus.ma_cr_read_en)
            read_value <= read_legal ? read_mux : 32'h0;

         // Snapshot the high half together with the low-half read so a
         // following CYCLE_HI read is coherent across a 2^32 carry.
         if (read_legal && cr_index == CR_CYCLE_LO)
            cycle_hi <= cycle_count[63:32];

         if (bus.ma_cr_write_en && ex_ok) begin
            if (cr_index == CR_SCRATCH0) scratch0[bus.ex_strand] <= bus.ma_cr_write_value;
            if (cr_index == CR_SCRATCH1) scratch1[bus.ex_strand] <= bus.ma_cr_write_value;
         end

         // RW1C clear is applied before the fault, so a same-cycle clear and
         // fault latches the new fault fresh.
         for (int s = 0; s < NUM_STRANDS; s++) begin
            pending[s] <= (pending[s] & ~pending_clear[s]) | fault_hit[s];
            if (fault_hit[s]) begin
               if (pending[s] && !pending_clear[s]) begin
                  double_fault[s] <= 1'b1;
               end else begin
                  saved_pc[s]     <= wb_fault_pc;
                  fault_cause[s]  <= wb_fault_cause;
                  double_fault[s] <= 1'b0;
               end
            end else if (pending_clear[s]) begin
               double_fault[s] <= 1'b0;
            end
         end
      end
   end

   assign cr_strand_enable             = strand_enable;
   assign cr_exception_handler_address = handler;
   assign cr_fault_pending             = pending;
   assign bus.cr_read_value            = read_value;

   rw_exclusive_a: assert property (@(posedge clk) disable iff (!reset_n)
      !(bus.ma_cr_read_en && bus.ma_cr_write_en));

endmodule

// File: doc/strand_control_registers.md
# strand_control_registers

Parametrised next-generation control register block for a GPGPU core. It supplies per-strand system state to the memory-access and writeback stages: strand ID, enable mask, exception handler, per-strand fault PC, cause and pending flag, per-strand scratch registers, and a free-running 64-bit cycle counter with atomic high-half snapshot. Reads are registered with one-cycle latency. The block sits beside the memory-access stage and feeds the writeback mux and the strand scheduler.

## Interface
- NUM_STRANDS, 4: strands per core, 1..32.
- CORE_ID, 0: core number reported in STRAND_ID.
- RESET_HANDLER, 32'h0: reset value of the exception handler address.
- SIW (localparam): max(1, $clog2(NUM_STRANDS)).

Ports:
- clk  in  1  clock.
- reset_n  in  1  active-low synchronous reset.
- cr_strand_enable  out  NUM_STRANDS  strand run mask to the scheduler.
- cr_exception_handler_address  out  32  fault vector.
- cr_fault_pending  out  NUM_STRANDS  per-strand unacknowledged fault.
- wb_latch_fault  in  1  fault report strobe.
- wb_fault_pc  in  32  faulting PC.
- wb_fault_cause  in  4  fault cause code.
- wb_fault_strand  in  SIW  faulting strand.
- ex_strand  in  SIW  strand performing the access.
- ma_cr_index  in  5  register index.
- ma_cr_read_en  in  1  read strobe.
- ma_cr_write_en  in  1  write strobe.
- ma_cr_write_value  in  32  write data.
- cr_read_value  out  32  read data, valid one cycle after ma_cr_read_en.

## Operation
Register map (index: access, meaning):
- 0 STRAND_ID: RO. Returns (CORE_ID << SIW) | ex_strand.
- 1 EXCEPTION_HANDLER: RW.
- 2 FAULT_ADDRESS: RO. Saved PC of ex_strand.
- 3 FAULT_CAUSE: RO. Bits [3:0] hold the cause. Bit 31 is sticky double-fault. All other bits read 0.
- 4 STRAND_ENABLE: RW. Writes use bits [NUM_STRANDS-1:0]. Reads zero-extend.
- 5 HALT_STRAND: WO. Clears the enable bit of ex_strand.
- 6 RESUME_STRAND: WO. Sets the enable bit indexed by write_value[SIW-1:0]. Indices ≥ NUM_STRANDS are ignored.
- 7 HALT: WO. Clears all enable bits.
- 8 CYCLE_LO: RO. Returns count[31:0] and latches count[63:32] into the hi snapshot in the same cycle.
- 9 CYCLE_HI: RO. Returns the hi snapshot.
- 10/11 SCRATCH0/1: RW. Per strand, indexed by ex_strand.
- 12 FAULT_PENDING: RW1C. Reads the pending mask. Writing 1 clears the corresponding pending bit and double-fault bit.
- Any other index: reads return 0, writes are ignored.

Fault latch:
- wb_latch_fault with pending[s] = 0: saved_pc[s] ← wb_fault_pc, cause[s] ← wb_fault_cause, pending[s] ← 1.
- wb_latch_fault with pending[s] = 1: pc and cause are kept. Double-fault[s] ← 1.
- Same-cycle RW1C clear and new fault on the same strand: the clear applies first, then the fault latches fresh. Result: new pc/cause, pending = 1, double = 0.

Cycle counter:
- 64-bit.
- Increments every cycle from 0 after reset.
- Wraps from 2^64-1 to 0.

Other rules:
- Read and write in the same cycle is illegal and is flagged by an assertion. In that case the write still takes effect and cr_read_value ← 0.
- Reads of fault state return pre-update values, because reads sample registers at the access cycle.

## Timing
Reset (reset_n = 0 at a clk edge) sets:
- cr_strand_enable = 1 (strand 0 only).
- handler = RESET_HANDLER.
- pending, double, cause, saved_pc, scratch, count, hi snapshot = 0.
- cr_read_value = 0.

Latency:
- Reads: cr_read_value updates on the edge after ma_cr_read_en and holds until the next read.
- Writes: visible on outputs one cycle after ma_cr_write_en.
- Faults: cr_fault_pending rises one cycle after wb_latch_fault.

Boundary behaviour:
- Reset asserted mid-operation overrides any same-cycle write or fault.
- A CYCLE_LO read returns the count value of the access cycle. A CYCLE_HI read in the following cycle returns the matching high half, even across a 2^32 carry.

## Test plan
- Reset then read STRAND_ID from strand 2 with CORE_ID = 3, NUM_STRANDS = 4 → cr_read_value = 32'h0000000E one cycle later. Enable mask = 4'b0001.
- Write STRAND_ENABLE = 32'hF, HALT_STRAND from strand 1, RESUME_STRAND value 1 → mask goes 4'b1111, then 4'b1101, then 4'b1111. HALT → 4'b0000.
- Fault on strand 3 (pc 32'h1000, cause 5), then a second fault (pc 32'h2000) → FAULT_ADDRESS = 32'h1000, FAULT_CAUSE = 32'h80000005, pending = 4'b1000. RW1C write 32'h8 → pending = 0, cause bit 31 cleared.
- Same-cycle RW1C clear and new fault on strand 0 (pc 32'h44) → pending[0] = 1, saved PC = 32'h44, double = 0.
- Force count to 32'hFFFFFFFF low half, read CYCLE_LO then CYCLE_HI → LO = 32'hFFFFFFFF, HI = pre-carry value. Counter wrap at 2^64-1 → 0.
- SCRATCH0 write 32'hA5 from strand 1 → reading SCRATCH0 from strand 0 returns 0, from strand 1 returns 32'hA5. Undefined index 31 reads 0.
